fetch_sequencer: RTL

Program-counter and fetch controller for the 16-bit instruction memory. Drives the memory address every cycle and tracks the one-cycle read latency. Buffers returned words in a 2-entry output queue so decode can stall without losing or duplicating instructions. Accepts branch redirects, and sits between the instruction memory and the decode stage.

---
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch-to-decode handshake bundle
//
// Purpose: carries the head of the fetch output queue to decode.
// Ports (signals):
//   fetch_valid  queue non-empty (driven by master)
//   fetch_instr  instruction at queue head (driven by master)
//   fetch_pc     PC of instruction at queue head (driven by master)
//   fetch_ready  decode accepts head this cycle (driven by slave)
// Modports: master = fetch sequencer, slave = decode stage.
interface fetch_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_instr;
   logic [ADDR_W-1:0] fetch_pc;
   logic              fetch_ready;

   modport master (
      output fetch_valid,
      output fetch_instr,
      output fetch_pc,
      input  fetch_ready
   );

   modport slave (
      input  fetch_valid,
      input  fetch_instr,
      input  fetch_pc,
      output fetch_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and fetch controller with 2-entry output queue
//
// Purpose: drives the instruction memory address every cycle, tracks the single
// outstanding one-cycle read, and buffers returned words so decode can stall.
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-low reset
//   enable          1 = fetch, 0 = stop issuing and drain
//   redirect_valid  branch/jump redirect strobe
//   redirect_addr   redirect target PC
//   imem_addr       address to instruction memory (combinational)
//   imem_instr      memory read data, valid the cycle after the address is sampled
//   fetch           fetch_sequencer_if.master: valid/instr/pc/ready to decode
//   busy            state != IDLE or a read is in flight
module fetch_sequencer #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 redirect_valid,
   input  logic [ADDR_W-1:0]    redirect_addr,
   output logic [ADDR_W-1:0]    imem_addr,
   input  logic [DATA_W-1:0]    imem_instr,
   fetch_sequencer_if.master    fetch,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_pc;

   // Queue entry 0 is always the head; entry 1 is only meaningful when count==2.
   logic [1:0]        count;
   logic [ADDR_W-1:0] q0_pc;
   logic [DATA_W-1:0] q0_instr;
   logic [ADDR_W-1:0] q1_pc;
   logic [DATA_W-1:0] q1_instr;

   logic              pop;
   logic              push;
   logic              issue;
   logic [2:0]        occupancy;

   assign pop       = (count != 2'd0) && fetch.fetch_ready;
   assign imem_addr = (redirect_valid && state == RUN) ? redirect_addr : pc;

   // Entries that will hold queue slots after this edge if we do not issue:
   // queued words plus the word landing now, minus the one decode takes.
   assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

   // A redirect empties the queue and squashes the inflight read, so the
   // target can always be issued regardless of the current occupancy.
   assign issue = (state == RUN) && enable && (redirect_valid || occupancy <= 3'd1);

   // A squashed read still completes at the memory but is never queued.
   assign push = inflight && !redirect_valid;

   assign fetch.fetch_valid = (count != 2'd0);
   assign fetch.fetch_instr = q0_instr;
   assign fetch.fetch_pc    = q0_pc;
   assign busy              = (state != IDLE) || inflight;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= 2'd0;
         q0_pc       <= '0;
         q0_instr    <= '0;
         q1_pc       <= '0;
         q1_instr    <= '0;
      end else begin
         case (state)
            IDLE:    if (enable)    state <= RUN;
            RUN:     if (!enable)   state <= DRAIN;
            DRAIN:   if (!inflight) state <= IDLE;
            default: state <= IDLE;
         endcase

         inflight <= issue;
         if (issue) begin
            inflight_pc <= imem_addr;
            pc          <= imem_addr + ADDR_W'(1);
         end else if (redirect_valid) begin
            pc <= redirect_addr;
         end

         if (redirect_valid) begin
            count <= 2'd0;
         end else begin
            case ({pop, push})
               2'b10: begin
                  q0_pc    <= q1_pc;
                  q0_instr <= q1_instr;
                  count    <= count - 2'd1;
               end
               2'b01: begin
                  if (count == 2'd0) begin
                     q0_pc    <= inflight_pc;
                     q0_instr <= imem_instr;
                  end else begin
                     q1_pc    <= inflight_pc;
                     q1_instr <= imem_instr;
                  end
                  count <= count + 2'd1;
               end
               2'b11: begin
                  // Count is unchanged; the new word goes behind whatever remains.
                  if (count == 2'd1) begin
                     q0_pc    <= inflight_pc;
                     q0_instr <= imem_instr;
                  end else begin
                     q0_pc    <= q1_pc;
                     q0_instr <= q1_instr;
                     q1_pc    <= inflight_pc;
                     q1_instr <= imem_instr;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
